// File: rtl/locked_sec_pipe.sv
// locked_sec_pipe: two-stage pipelined single-error-correcting (Hamming SEC)
// corrector with key-gated logic locking.
//
// Data bit i sits at code position p(i), the (i+1)-th integer >= 3 that is
// not a power of two. The data path is only correct when the serially loaded
// key is the correct one.
//
// Key layout, LSB first on key_in:
//   key[XK_IN-1:0]             input XOR mask on data bits 0..XK_IN-1
//   key[XK_IN+XK_OUT-1:XK_IN]  output XOR mask on data bits 0..XK_OUT-1
//   key[KEY_W-1:KEY_W-4]       4-entry mux key m that produces syndrome bit 0
//
// Ports:
//   clk, rst_n             clock and synchronous active-low reset
//   key_start, key_in      key (re)load request and serial key bit
//   key_loaded             high while a key is installed (ACTIVE state)
//   in_valid/in_ready      input handshake for in_data, in_chk and chk_en
//   out_valid/out_ready    output handshake for out_data, out_corr, out_uncorr
module locked_sec_pipe #(
  parameter int DATA_W = 32,
  parameter int XK_IN  = 16,
  parameter int XK_OUT = 11,
  localparam int CHK_W = (DATA_W <= 4)   ? 3 :
                         (DATA_W <= 11)  ? 4 :
                         (DATA_W <= 26)  ? 5 :
                         (DATA_W <= 57)  ? 6 :
                         (DATA_W <= 120) ? 7 :
                         (DATA_W <= 247) ? 8 :
                         (DATA_W <= 502) ? 9 : 10,
  localparam int KEY_W = XK_IN + XK_OUT + 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_start,
  input  logic              key_in,
  output logic              key_loaded,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_chk,
  input  logic              chk_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_corr,
  output logic              out_uncorr
);

  // Position of data bit idx in the code word.
  function automatic int code_pos(input int idx);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int k = 3; k < 4 * DATA_W + 16; k++) begin
      if ((k & (k - 1)) != 0) begin
        if (cnt == idx) res = k;
        cnt++;
      end
    end
    return res;
  endfunction

  localparam int CNT_W = $clog2(KEY_W);
  localparam logic [CHK_W-1:0] PMAX = CHK_W'(code_pos(DATA_W - 1));

  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;

  state_t             state, state_next;
  logic [KEY_W-1:0]   key_reg;
  logic [CNT_W-1:0]   cnt;
  logic               pending;

  logic               s1_v;
  logic [DATA_W-1:0]  s1_data;
  logic [CHK_W-1:0]   s1_syn;
  logic               s2_v;
  logic [DATA_W-1:0]  s2_data;
  logic               s2_corr;
  logic               s2_uncorr;

  logic               s2_free;
  logic               s1_adv;
  logic               in_fire;
  logic               go_load;
  logic               last_bit;

  logic [DATA_W-1:0]  in_mask;
  logic [DATA_W-1:0]  out_mask;
  logic [3:0]         mux_key;
  logic [DATA_W-1:0]  masked;
  logic [CHK_W-1:0]   contrib [DATA_W];
  logic [CHK_W-1:0]   parity;
  logic [CHK_W-1:0]   syn;
  logic [DATA_W-1:0]  flip;

  assign in_mask  = DATA_W'(key_reg[XK_IN-1:0]);
  assign out_mask = DATA_W'(key_reg[XK_IN+XK_OUT-1:XK_IN]);
  assign mux_key  = key_reg[KEY_W-1:KEY_W-4];
  assign masked   = in_data ^ in_mask;

  // Handshake plumbing: stage 2 accepts when empty or draining; stage 1
  // moves forward only when it holds a word and stage 2 can take it.
  assign s2_free  = !s2_v || out_ready;
  assign s1_adv   = s1_v && s2_free;
  assign in_fire  = in_valid && in_ready;
  assign last_bit = (cnt == CNT_W'(KEY_W - 1));

  // A pending or fresh reload waits until no word is in flight or entering.
  assign go_load  = (key_start || pending) && !s1_v && !s2_v && !in_fire;

  // Per-bit syndrome contribution and correction decode.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
    localparam int P = code_pos(gi);
    assign contrib[gi] = masked[gi] ? CHK_W'(P) : '0;
    assign flip[gi]    = (s1_syn == CHK_W'(P));
  end

  always_comb begin
    parity = '0;
    for (int i = 0; i < DATA_W; i++) parity ^= contrib[i];
    syn = parity ^ (in_chk & {CHK_W{chk_en}});
    // Syndrome bit 0 goes through the key mux; m = 4'b0110 reproduces XOR.
    syn[0] = mux_key[{parity[0], chk_en & in_chk[0]}];
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM: next state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (key_start) state_next = LOAD;
      LOAD:    if (!key_start && last_bit) state_next = ACTIVE;
      ACTIVE:  if (go_load) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    key_loaded = (state == ACTIVE);
    in_ready   = (state == ACTIVE) && !pending && (!s1_v || s1_adv);
  end

  // Key shift register and bit counter. key_start inside LOAD restarts the
  // count without sampling key_in that cycle, same as the initial entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_reg <= '0;
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      if (state == LOAD && !key_start) begin
        key_reg <= {key_in, key_reg[KEY_W-1:1]};
        cnt     <= last_bit ? '0 : cnt + 1'b1;
      end else begin
        cnt     <= '0;
      end
      pending <= (state == ACTIVE) && (key_start || pending) && !go_load;
    end
  end

  // Stage 1: masked data and syndrome.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_data <= '0;
      s1_syn  <= '0;
    end else if (!s1_v || s1_adv) begin
      s1_v <= in_fire;
      if (in_fire) begin
        s1_data <= masked;
        s1_syn  <= syn;
      end
    end
  end

  // Stage 2: corrected, output-masked data and flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_v      <= 1'b0;
      s2_data   <= '0;
      s2_corr   <= 1'b0;
      s2_uncorr <= 1'b0;
    end else if (s2_free) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_data   <= s1_data ^ flip ^ out_mask;
        s2_corr   <= (s1_syn != '0) && (s1_syn <= PMAX);
        s2_uncorr <= (s1_syn > PMAX);
      end
    end
  end

  assign out_valid  = s2_v;
  assign out_data   = s2_data;
  assign out_corr   = s2_corr;
  assign out_uncorr = s2_uncorr;

endmodule

// File: tb/tb_locked_sec_pipe.sv
// tb_locked_sec_pipe: directed bench for locked_sec_pipe (DATA_W = 32).
// Code positions used below: p(0..7) = 3,5,6,7,9,10,11,12 and p(31) = 38.
module tb_locked_sec_pipe;

  localparam logic [30:0] KEY_OK  = {4'b0110, 11'd0, 16'd0};
  localparam logic [30:0] KEY_IM0 = {4'b0110, 11'd0, 16'd1};
  localparam logic [30:0] KEY_OM0 = {4'b0110, 11'd1, 16'd0};
  localparam logic [30:0] KEY_MUX = {4'b1001, 11'd0, 16'd0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_start;
  logic        key_in;
  logic        key_loaded;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [5:0]  in_chk;
  logic        chk_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_corr;
  logic        out_uncorr;

  int checks = 0;
  int errors = 0;

  locked_sec_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_start  (key_start),
    .key_in     (key_in),
    .key_loaded (key_loaded),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_chk     (in_chk),
    .chk_en     (chk_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_corr   (out_corr),
    .out_uncorr (out_uncorr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_key(input logic [30:0] k, input string tag);
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    check({tag, "_enter"}, key_loaded, 1'b0);
    for (int i = 0; i < 31; i++) begin
      key_in = k[i];
      if (i == 30) check({tag, "_lastbit"}, key_loaded, 1'b0);
      tick();
    end
    check({tag, "_loaded"}, key_loaded, 1'b1);
    check({tag, "_ready"}, in_ready, 1'b1);
    $display("key load %s: key=%08h", tag, k);
  endtask

  task automatic send_word(input logic [31:0] d, input logic [5:0] c, input logic en,
                           input logic [31:0] exp_d, input logic exp_c, input logic exp_u,
                           input string tag);
    in_data   = d;
    in_chk    = c;
    chk_en    = en;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check({tag, "_lat1"}, out_valid, 1'b0);
    tick();
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, exp_d);
    check({tag, "_corr"}, out_corr, exp_c);
    check({tag, "_uncorr"}, out_uncorr, exp_u);
    $display("word %s: in=%08h chk=%02h en=%0b -> out=%08h corr=%0b uncorr=%0b",
             tag, d, c, en, out_data, out_corr, out_uncorr);
    tick();
    check({tag, "_drained"}, out_valid, 1'b0);
  endtask

  initial begin
    logic [5:0]  ctab [8];
    logic [3:0]  pat;
    logic [31:0] held_data;
    logic        held;
    logic        got_load;
    int          sent;
    int          recv;
    int          drained;

    ctab = '{6'd3, 6'd5, 6'd6, 6'd7, 6'd9, 6'd10, 6'd11, 6'd12};
    pat  = 4'b1001;

    rst_n = 1'b0; key_start = 1'b0; key_in = 1'b0; in_valid = 1'b0;
    in_data = '0; in_chk = '0; chk_en = 1'b1; out_ready = 1'b1;
    tick();
    tick();
    check("rst_key_loaded", key_loaded, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_corr", out_corr, 1'b0);
    check("rst_out_uncorr", out_uncorr, 1'b0);
    rst_n = 1'b1;
    tick();
    check("idle_key_loaded", key_loaded, 1'b0);
    check("idle_in_ready", in_ready, 1'b0);

    // Correct key: plain decoding behaviour.
    load_key(KEY_OK, "ok");
    send_word(32'h0, 6'h00, 1'b1, 32'h0, 1'b0, 1'b0, "zero");
    send_word(32'h20, 6'h00, 1'b1, 32'h0, 1'b1, 1'b0, "bit5_err");
    send_word(32'h20, 6'd10, 1'b1, 32'h20, 1'b0, 1'b0, "bit5_code");
    send_word(32'h1, 6'd3, 1'b1, 32'h1, 1'b0, 1'b0, "bit0_code");
    send_word(32'h80000000, 6'h00, 1'b1, 32'h0, 1'b1, 1'b0, "bit31_err");
    send_word(32'h0, 6'd38, 1'b1, 32'h80000000, 1'b1, 1'b0, "syn38");
    send_word(32'h0, 6'd39, 1'b1, 32'h0, 1'b0, 1'b1, "syn39");
    send_word(32'h0, 6'h3f, 1'b1, 32'h0, 1'b0, 1'b1, "syn63");
    send_word(32'h0, 6'h3f, 1'b0, 32'h0, 1'b0, 1'b0, "chk_off");

    // Stream 8 codewords with out_ready following 1,0,0,1.
    sent = 0; recv = 0; held = 1'b0; held_data = '0; chk_en = 1'b1;
    for (int cyc = 0; cyc < 100 && recv < 8; cyc++) begin
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 8);
      in_data   = (sent < 8) ? (32'd1 << sent) : 32'd0;
      in_chk    = (sent < 8) ? ctab[sent] : 6'd0;
      #1;
      if (held) begin
        check("stream_hold_valid", out_valid, 1'b1);
        check("stream_hold_data", out_data, held_data);
      end
      if (out_valid && out_ready) begin
        check("stream_data", out_data, 32'd1 << recv);
        check("stream_corr", out_corr, 1'b0);
        $display("stream word %0d: out=%08h", recv, out_data);
        recv++;
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    check("stream_count", recv, 8);
    check("stream_sent", sent, 8);
    tick();
    check("stream_empty", out_valid, 1'b0);

    // key_start with two words in flight; the new key sets output mask bit 0.
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 32'h20; in_chk = 6'd10;
    tick();
    in_data = 32'h40; in_chk = 6'd11;
    tick();
    in_valid  = 1'b0;
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    check("pend_in_ready", in_ready, 1'b0);
    check("pend_key_loaded", key_loaded, 1'b1);
    check("pend_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    key_in    = KEY_OM0[0];
    drained   = 0;
    got_load  = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (!key_loaded) begin
        got_load = 1'b1;
        break;
      end
      check("pend_in_ready_drain", in_ready, 1'b0);
      if (out_valid) begin
        check("pend_drain_data", out_data, (drained == 0) ? 32'h20 : 32'h40);
        $display("drain word %0d: out=%08h", drained, out_data);
        drained++;
      end
      tick();
    end
    check("pend_got_load", got_load, 1'b1);
    check("pend_drained", drained, 2);
    for (int i = 0; i < 31; i++) begin
      key_in = KEY_OM0[i];
      if (i == 30) check("pend_lastbit", key_loaded, 1'b0);
      tick();
    end
    check("pend_loaded", key_loaded, 1'b1);
    send_word(32'h0, 6'h00, 1'b1, 32'h1, 1'b0, 1'b0, "out_mask0");

    load_key(KEY_IM0, "im0");
    send_word(32'h0, 6'h00, 1'b1, 32'h0, 1'b1, 1'b0, "in_mask0");

    load_key(KEY_MUX, "mux1001");
    send_word(32'h0, 6'h00, 1'b1, 32'h0, 1'b1, 1'b0, "mux_s1");

    // Reset in the middle of traffic.
    load_key(KEY_OK, "ok2");
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 32'h1; in_chk = 6'd3; chk_en = 1'b1;
    tick();
    tick();
    check("mid_out_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    tick();
    check("mrst_out_valid", out_valid, 1'b0);
    check("mrst_key_loaded", key_loaded, 1'b0);
    check("mrst_in_ready", in_ready, 1'b0);
    check("mrst_out_data", out_data, 32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();
    check("mrst_idle_loaded", key_loaded, 1'b0);
    check("mrst_idle_valid", out_valid, 1'b0);
    $display("mid-stream reset: out_valid=%0b key_loaded=%0b", out_valid, key_loaded);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
